// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Brief    : Shared constants, FSM state type and helpers for the PS/2 receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PAUSE_CODE = 8'h77;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int KEY_CHG = 10;
    localparam int KEY_BRK = 9;
    localparam int KEY_EXT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Keyboard self-test / ack / echo / resend / error replies, not key events.
    function automatic logic is_response(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_response = 1'b1;
            default:                                         is_response = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_filter.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_filter
//  Brief    : Synchronises and glitch-filters the PS/2 pins; flags clock falls.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_f,
    output logic sample
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [1:0] w_raw;
    logic [1:0] w_lvl;
    logic       clk_prev_q;

    assign w_raw = {ps2_data, ps2_clk};

    for (genvar i = 0; i < 2; i++) begin : g_pin
        logic [1:0]    sync_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          lvl_q, lvl_d;

        // Level flips on the FILTER_LEN-th consecutive sample that disagrees.
        always_comb begin
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            if (sync_q[1] == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                lvl_d = ~lvl_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= 2'b11;
                cnt_q  <= '0;
                lvl_q  <= 1'b1;
            end else begin
                sync_q <= {sync_q[0], w_raw[i]};
                cnt_q  <= cnt_d;
                lvl_q  <= lvl_d;
            end
        end

        assign w_lvl[i] = lvl_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) clk_prev_q <= 1'b1;
        else       clk_prev_q <= w_lvl[0];
    end

    assign sample = clk_prev_q & ~w_lvl[0];
    assign data_f = w_lvl[1];

endmodule
`default_nettype wire

// File: rtl/ps2_key_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_rx
//  Brief    : PS/2 set-2 receiver; folds E0/F0/E1 prefixes into ps2_key events.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ena,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        err
);
    import ps2_pkg::*;

    localparam int WDW = $clog2(TIMEOUT + 1);

    logic             data_f, sample;
    ps2_state_t       state_q, state_d;
    logic [7:0]       shift_q;
    logic [2:0]       bitcnt_q;
    logic             par_q;
    logic [WDW-1:0]   wd_q;
    logic             byte_done, frame_err, timeout;
    logic             ext_q, ext_d, brk_q, brk_d;
    logic [2:0]       skip_q, skip_d;
    logic             post;
    logic [KEY_BRK:0] post_key, key_q;
    logic             pending_q, err_q, chg, overrun;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_f   (data_f),
        .sample   (sample)
    );

    assign timeout = (state_q != IDLE) && !sample && (wd_q == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else if (sample) begin
            case (state_q)
                IDLE:    if (!data_f) state_d = DATA;
                DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        byte_done = 1'b0;
        frame_err = 1'b0;
        if (state_q == STOP && sample) begin
            if (data_f && (^{shift_q, par_q})) byte_done = 1'b1;
            else                               frame_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            wd_q <= (state_q == IDLE || sample) ? '0 : wd_q + WDW'(1);
            if (state_q == IDLE) bitcnt_q <= '0;
            if (sample && state_q == DATA) begin
                shift_q  <= {data_f, shift_q[7:1]};
                bitcnt_q <= bitcnt_q + 3'd1;
            end
            if (sample && state_q == PARITY) par_q <= data_f;
        end
    end

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        post     = 1'b0;
        post_key = '0;
        if (byte_done) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
                if (skip_q == 3'd1) begin
                    post              = 1'b1;
                    post_key[KEY_EXT] = 1'b1;
                    post_key[7:0]     = PAUSE_CODE;
                end
            end else if (shift_q == PS2_PAUSE) begin
                skip_d = PAUSE_SKIP;
            end else if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
                brk_d = 1'b1;
            end else if (!(is_response(shift_q) && !ext_q && !brk_q)) begin
                post              = 1'b1;
                post_key[KEY_BRK] = brk_q;
                post_key[KEY_EXT] = ext_q;
                post_key[7:0]     = shift_q;
                ext_d             = 1'b0;
                brk_d             = 1'b0;
            end
        end
    end

    // A strobe in the same cycle as a post frees the slot, so that is no overrun.
    assign chg     = pending_q & clk_ena;
    assign overrun = post & pending_q & ~clk_ena;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            skip_q    <= '0;
            key_q     <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            skip_q    <= skip_d;
            if (post) key_q <= post_key;
            pending_q <= post | (pending_q & ~clk_ena);
            err_q     <= frame_err | timeout | overrun;
        end
    end

    assign ps2_key = {chg, key_q};
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_rx
//  Brief    : Directed self-checking bench for the PS/2 key receiver.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_rx;

    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_ena = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        err;

    int   n_checks = 0;
    int   n_errors = 0;
    int   strb_cnt = 0;
    int   err_cnt  = 0;
    int   bad_ena  = 0;
    int   ena_cnt  = 0;
    logic ena_mode = 1'b0;
    logic [10:0] last_key = '0;

    ps2_key_rx #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_ena  (clk_ena),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        ena_cnt = ena_cnt + 1;
        clk_ena = ena_mode ? (ena_cnt % 4 == 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (ps2_key[10]) begin
            strb_cnt = strb_cnt + 1;
            last_key = ps2_key;
            if (!clk_ena) bad_ena = bad_ena + 1;
        end
        if (err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        strb_cnt = 0;
        err_cnt  = 0;
        bad_ena  = 0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (15) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (30) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ bad_par);
        send_bit(1'b1);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        repeat (3) @(negedge clk);
        check("rst_key", 32'(ps2_key), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        clr(); send_frame(8'h1C, 1'b0);
        check("a_strobes", strb_cnt, 1);
        check("a_key", 32'(last_key), 32'h41C);
        check("a_err", err_cnt, 0);

        clr(); send_frame(8'hE0, 1'b0);
        check("e0_nostrobe", strb_cnt, 0);
        send_frame(8'hF0, 1'b0);
        check("f0_nostrobe", strb_cnt, 0);
        send_frame(8'h75, 1'b0);
        check("up_brk_strobes", strb_cnt, 1);
        check("up_brk_key", 32'(last_key), 32'h775);
        clr(); send_frame(8'h75, 1'b0);
        check("up_make_key", 32'(last_key), 32'h475);

        clr(); send_frame(8'hAA, 1'b0);
        check("resp_drop", strb_cnt, 0);

        clr();
        for (int i = 0; i < 7; i++) send_frame(pause_seq[i], 1'b0);
        check("pause_early", strb_cnt, 0);
        send_frame(pause_seq[7], 1'b0);
        check("pause_strobes", strb_cnt, 1);
        check("pause_key", 32'(last_key), 32'h577);

        clr(); send_frame(8'h1C, 1'b1);
        check("par_err", err_cnt, 1);
        check("par_nostrobe", strb_cnt, 0);
        clr(); send_frame(8'h1C, 1'b0);
        check("par_recover", 32'(last_key), 32'h41C);

        clr();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TO + 10) @(negedge clk);
        check("to_err", err_cnt, 1);
        check("to_strobe", strb_cnt, 0);
        check("to_state", 32'(dut.state_q), 32'h0);
        clr(); send_frame(8'h12, 1'b0);
        check("to_recover", 32'(last_key), 32'h412);

        ena_mode = 1'b1;
        clr(); send_frame(8'h1C, 1'b0);
        check("ena_strobes", strb_cnt, 1);
        check("ena_aligned", bad_ena, 0);
        check("ena_key", 32'(last_key), 32'h41C);
        ena_mode = 1'b0;

        clr();
        @(negedge clk) ps2_data = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_state", 32'(dut.state_q), 32'h0);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h1C, 1'b0);
        check("glitch_key", 32'(last_key), 32'h41C);
        check("glitch_err", err_cnt, 0);

        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_key", 32'(ps2_key), 32'h0);
        check("midrst_state", 32'(dut.state_q), 32'h0);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        clr(); send_frame(8'h5A, 1'b0);
        check("post_rst_key", 32'(last_key), 32'h45A);
        check("post_rst_strobes", strb_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
